// File: rtl/uart_pkg.sv
// Shared constants, state encoding and helpers for the UART receive path.
package uart_pkg;

  // Sample ticks per bit; the tick counter below is sized for exactly 16.
  localparam int OVERSAMPLE = 16;

  // Tick indices within a bit at which the line is sampled for the vote.
  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'd15;

  // Index of the last data bit (8 data bits, LSB first).
  localparam logic [2:0] BIT_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int baud_div(input int clk_freq, input int baud);
    int den;
    int div;
    den = baud * OVERSAMPLE;
    div = (clk_freq + (den / 2)) / den;
    if (div < 1) begin
      div = 1;
    end else begin
      div = div;
    end
    return div;
  endfunction

  // Two-out-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-Clk pulse every DIV clocks, held idle by clr.
// Kept free of receiver specifics so the transmitter can share it.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clr,
  output logic tick
);

  localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Next divider count and tick pulse; clr restarts the bit phase from zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
    end
  end

  // Divider state and registered tick output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronises the line, oversamples 16x, votes three
// mid-bit samples and assembles bytes LSB first. Bytes with a low stop bit
// are discarded and flagged so they never reach the downstream decoder.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD);

  // Line synchroniser and edge history, all idle-high.
  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Receiver state.
  rx_state_e  state_q,     state_d;
  logic [3:0] tick_cnt_q,  tick_cnt_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [1:0] vote_q,      vote_d;
  logic [7:0] shift_q,     shift_d;
  logic       armed_q,     armed_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_done_q,   rx_done_d;
  logic       frame_err_q, frame_err_d;

  logic tick_s;
  logic clr_s;
  logic fall_s;
  logic decide_s;
  logic bit_end_s;
  logic bit_val_s;

  // The divider only runs while a frame is in progress.
  assign clr_s = (state_q == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  assign fall_s    = prev_q & ~sync2_q;
  assign decide_s  = tick_s & (tick_cnt_q == SAMPLE_C);
  assign bit_end_s = tick_s & (tick_cnt_q == TICK_LAST);
  // Third sample is taken live from the synchroniser at the decision tick.
  assign bit_val_s = maj3(vote_q[1], vote_q[0], sync2_q);

  // Two-stage synchroniser plus one history stage for falling-edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state, bit timing, vote capture, byte assembly and output pulses.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    // Within a frame: advance the tick counter and latch the first two votes.
    if (tick_s) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick_cnt_q == SAMPLE_A) begin
        vote_d[0] = sync2_q;
      end else if (tick_cnt_q == SAMPLE_B) begin
        vote_d[1] = sync2_q;
      end else begin
        vote_d = vote_q;
      end
    end else begin
      tick_cnt_d = tick_cnt_q;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        vote_d     = 2'b00;
        // Only re-arm after the line has been seen high, so a held break
        // cannot start a second frame.
        if (armed_q && fall_s) begin
          state_d = START;
          armed_d = 1'b0;
        end else if (sync2_q) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end

      START: begin
        if (decide_s) begin
          if (bit_val_s) begin
            state_d = IDLE;  // start bit did not hold low: glitch
          end else begin
            state_d = START;
          end
        end else if (bit_end_s) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (decide_s) begin
          shift_d[bit_cnt_q] = bit_val_s;
        end else if (bit_end_s) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end

      STOP: begin
        // Leave half a bit early so a start bit that follows with no idle
        // time still produces a falling edge in IDLE.
        if (decide_s) begin
          state_d = IDLE;
          if (bit_val_s) begin
            rx_data_d = shift_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receiver state and registered outputs; reset drops any partial byte.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      vote_q      <= 2'b00;
      shift_q     <= 8'h00;
      armed_q     <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      vote_q      <= vote_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule
